// File: rtl/renode_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between several read masters.
// One burst in flight at a time; R beats return to the granted requester.
module renode_axi_read_arbiter #(
   parameter int AddressWidth       = 32,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8,
   parameter int NumRequesters      = 4
) (
   input  logic                                       clk,
   input  logic                                       areset,

   input  logic [NumRequesters-1:0]                   s_arvalid,
   output logic [NumRequesters-1:0]                   s_arready,
   input  logic [NumRequesters*TransactionIdWidth-1:0] s_arid,
   input  logic [NumRequesters*AddressWidth-1:0]      s_araddr,
   input  logic [NumRequesters*8-1:0]                 s_arlen,
   input  logic [NumRequesters*3-1:0]                 s_arsize,
   input  logic [NumRequesters*2-1:0]                 s_arburst,

   output logic [NumRequesters-1:0]                   s_rvalid,
   input  logic [NumRequesters-1:0]                   s_rready,
   output logic [TransactionIdWidth-1:0]              s_rid,
   output logic [DataWidth-1:0]                       s_rdata,
   output logic [1:0]                                 s_rresp,
   output logic                                       s_rlast,

   output logic                                       m_arvalid,
   input  logic                                       m_arready,
   output logic [TransactionIdWidth-1:0]              m_arid,
   output logic [AddressWidth-1:0]                    m_araddr,
   output logic [7:0]                                 m_arlen,
   output logic [2:0]                                 m_arsize,
   output logic [1:0]                                 m_arburst,

   input  logic                                       m_rvalid,
   output logic                                       m_rready,
   input  logic [TransactionIdWidth-1:0]              m_rid,
   input  logic [DataWidth-1:0]                       m_rdata,
   input  logic [1:0]                                 m_rresp,
   input  logic                                       m_rlast,

   output logic [$clog2(NumRequesters)-1:0]           grant_id,
   output logic                                       busy,
   output logic                                       len_err
);

   localparam int GW = $clog2(NumRequesters);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [GW-1:0] rr;
   logic [GW-1:0] pick;
   logic          pick_vld;
   logic [7:0]    arlen_q;
   logic [8:0]    beat_cnt;
   logic          err_seen;

   logic          ar_hs;
   logic          r_hs;
   logic          cnt_eq;
   logic          bad_last;
   logic          bad_over;
   logic          err_now;
   int            gsel;
   int            psel;

   function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base,
                                             input int k);
      int j;
      j = int'(base) + k;
      if (j >= NumRequesters) begin
         j = j - NumRequesters;
      end
      return GW'(j);
   endfunction

   // Scan starts just after the last winner, so it has lowest priority.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      for (int k = 1; k <= NumRequesters; k++) begin
         if (!pick_vld && s_arvalid[rr_idx(rr, k)]) begin
            pick_vld = 1'b1;
            pick     = rr_idx(rr, k);
         end
      end
   end

   always_comb begin
      gsel = int'(grant_id);
      psel = int'(pick);
   end

   always_comb begin
      m_arid    = s_arid[gsel*TransactionIdWidth +: TransactionIdWidth];
      m_araddr  = s_araddr[gsel*AddressWidth +: AddressWidth];
      m_arlen   = s_arlen[gsel*8 +: 8];
      m_arsize  = s_arsize[gsel*3 +: 3];
      m_arburst = s_arburst[gsel*2 +: 2];
   end

   always_comb begin
      s_rid   = m_rid;
      s_rdata = m_rdata;
      s_rresp = m_rresp;
      s_rlast = m_rlast;
   end

   always_comb begin
      ar_hs    = (state == ADDR) && m_arready;
      r_hs     = (state == DATA) && m_rvalid && m_rready;
      cnt_eq   = (beat_cnt == {1'b0, arlen_q});
      bad_last = r_hs && m_rlast && !cnt_eq;
      bad_over = r_hs && !m_rlast && cnt_eq;
      // At most one error report per burst.
      err_now  = (bad_last || bad_over) && !err_seen;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (m_arready) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (r_hs && m_rlast) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      s_arready = '0;
      s_rvalid  = '0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
         end
         ADDR: begin
            m_arvalid           = 1'b1;
            s_arready[grant_id] = m_arready;
            busy                = 1'b1;
         end
         DATA: begin
            m_rready           = s_rready[grant_id];
            s_rvalid[grant_id] = m_rvalid;
            busy               = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         grant_id <= '0;
         rr       <= GW'(NumRequesters - 1);
         arlen_q  <= '0;
         beat_cnt <= '0;
         err_seen <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         len_err <= err_now;
         if ((state == IDLE) && pick_vld) begin
            grant_id <= pick;
            arlen_q  <= s_arlen[psel*8 +: 8];
         end
         if (ar_hs) begin
            beat_cnt <= '0;
            err_seen <= 1'b0;
         end else if (r_hs) begin
            if (beat_cnt != 9'd256) begin
               beat_cnt <= beat_cnt + 9'd1;
            end
            if (err_now) begin
               err_seen <= 1'b1;
            end
            if (m_rlast) begin
               rr <= grant_id;
            end
         end
      end
   end

endmodule

// File: tb/tb_renode_axi_read_arbiter.sv
// Testbench for renode_axi_read_arbiter: directed scenarios plus random
// bursts checked against a round-robin / burst-length reference model.
module tb_renode_axi_read_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 8;
   localparam int GW = 2;

   logic              clk = 1'b0;
   logic              areset;

   logic [N-1:0]      s_arvalid;
   logic [N-1:0]      s_arready;
   logic [N*IW-1:0]   s_arid;
   logic [N*AW-1:0]   s_araddr;
   logic [N*8-1:0]    s_arlen;
   logic [N*3-1:0]    s_arsize;
   logic [N*2-1:0]    s_arburst;
   logic [N-1:0]      s_rvalid;
   logic [N-1:0]      s_rready;
   logic [IW-1:0]     s_rid;
   logic [DW-1:0]     s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rlast;
   logic              m_arvalid;
   logic              m_arready;
   logic [IW-1:0]     m_arid;
   logic [AW-1:0]     m_araddr;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic              m_rvalid;
   logic              m_rready;
   logic [IW-1:0]     m_rid;
   logic [DW-1:0]     m_rdata;
   logic [1:0]        m_rresp;
   logic              m_rlast;
   logic [GW-1:0]     grant_id;
   logic              busy;
   logic              len_err;

   logic [AW-1:0]     r_addr[N];
   logic [IW-1:0]     r_id[N];
   logic [7:0]        r_len[N];
   logic [2:0]        r_size[N];
   logic [1:0]        r_burst[N];

   int n_cmp = 0;
   int n_err = 0;
   int rr_m;

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign s_araddr[i*AW +: AW] = r_addr[i];
      assign s_arid[i*IW +: IW]   = r_id[i];
      assign s_arlen[i*8 +: 8]    = r_len[i];
      assign s_arsize[i*3 +: 3]   = r_size[i];
      assign s_arburst[i*2 +: 2]  = r_burst[i];
   end

   renode_axi_read_arbiter #(
      .AddressWidth(AW),
      .DataWidth(DW),
      .TransactionIdWidth(IW),
      .NumRequesters(N)
   ) dut (
      .clk(clk),
      .areset(areset),
      .s_arvalid(s_arvalid),
      .s_arready(s_arready),
      .s_arid(s_arid),
      .s_araddr(s_araddr),
      .s_arlen(s_arlen),
      .s_arsize(s_arsize),
      .s_arburst(s_arburst),
      .s_rvalid(s_rvalid),
      .s_rready(s_rready),
      .s_rid(s_rid),
      .s_rdata(s_rdata),
      .s_rresp(s_rresp),
      .s_rlast(s_rlast),
      .m_arvalid(m_arvalid),
      .m_arready(m_arready),
      .m_arid(m_arid),
      .m_araddr(m_araddr),
      .m_arlen(m_arlen),
      .m_arsize(m_arsize),
      .m_arburst(m_arburst),
      .m_rvalid(m_rvalid),
      .m_rready(m_rready),
      .m_rid(m_rid),
      .m_rdata(m_rdata),
      .m_rresp(m_rresp),
      .m_rlast(m_rlast),
      .grant_id(grant_id),
      .busy(busy),
      .len_err(len_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference round-robin: first requesting index after the last winner.
   function automatic int rr_pick(input logic [N-1:0] mask, input int last);
      for (int k = 1; k <= N; k++) begin
         if (((mask >> ((last + k) % N)) & N'(1)) != '0) begin
            return (last + k) % N;
         end
      end
      return -1;
   endfunction

   task automatic rand_fields();
      for (int i = 0; i < N; i++) begin
         r_addr[i]  = AW'($urandom);
         r_id[i]    = IW'($urandom);
         r_size[i]  = 3'($urandom_range(0, 7));
         r_burst[i] = 2'($urandom_range(0, 3));
         r_len[i]   = 8'($urandom_range(0, 5));
      end
   endtask

   // Caller has placed requests on s_arvalid while the arbiter is idle.
   task automatic do_txn(input int g, input int nbeats, input int ar_wait,
                         input bit toggle, input bit drop);
      logic [N-1:0]  gbit;
      logic [GW-1:0] gi;
      int            beat;
      int            guard;
      int            pulses;
      bit            rdy;
      gi   = GW'(g);
      gbit = N'(1) << g;
      #1;
      check("idle_arvalid", 64'(m_arvalid), 64'(0));
      check("idle_arready", 64'(s_arready), 64'(0));
      tick();
      check("grant_id", 64'(grant_id), 64'(g));
      check("addr_arvalid", 64'(m_arvalid), 64'(1));
      check("addr_busy", 64'(busy), 64'(1));
      check("araddr", 64'(m_araddr), 64'(r_addr[gi]));
      check("arid", 64'(m_arid), 64'(r_id[gi]));
      check("arlen", 64'(m_arlen), 64'(r_len[gi]));
      check("arsize", 64'(m_arsize), 64'(r_size[gi]));
      check("arburst", 64'(m_arburst), 64'(r_burst[gi]));
      for (int w = 0; w < ar_wait; w++) begin
         check("ar_wait_ready", 64'(s_arready), 64'(0));
         tick();
         check("ar_stable_addr", 64'(m_araddr), 64'(r_addr[gi]));
         check("ar_stable_valid", 64'(m_arvalid), 64'(1));
      end
      m_arready = 1'b1;
      #1;
      check("ar_ready_route", 64'(s_arready), 64'(gbit));
      tick();
      m_arready = 1'b0;
      if (drop) begin
         s_arvalid = s_arvalid & ~gbit;
      end
      beat   = 0;
      guard  = 0;
      pulses = 0;
      while (beat < nbeats && guard < 200) begin
         rdy      = toggle ? bit'(guard % 2) : 1'b1;
         m_rvalid = 1'b1;
         m_rlast  = (beat == nbeats - 1);
         m_rdata  = DW'($urandom);
         m_rid    = IW'($urandom);
         m_rresp  = 2'($urandom_range(0, 3));
         s_rready = (N'($urandom) & ~gbit) | (rdy ? gbit : '0);
         #1;
         pulses += int'(len_err);
         check("rvalid_route", 64'(s_rvalid), 64'(gbit));
         check("rready_track", 64'(m_rready), 64'(rdy));
         check("data_no_arready", 64'(s_arready), 64'(0));
         check("rdata", 64'(s_rdata), 64'(m_rdata));
         check("rid", 64'(s_rid), 64'(m_rid));
         check("rlast", 64'(s_rlast), 64'(m_rlast));
         if (rdy) begin
            beat++;
         end
         guard++;
         tick();
      end
      if (guard >= 200) begin
         n_cmp++;
         n_err++;
         $error("FAIL beat_timeout: observed %0d beats expected %0d",
                beat, nbeats);
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = '0;
      pulses += int'(len_err);
      check("end_busy", 64'(busy), 64'(0));
      check("len_err_pulses", 64'(pulses),
            64'((nbeats != int'(r_len[gi]) + 1) ? 1 : 0));
      rr_m = g;
   endtask

   initial begin
      int g;
      int nb;
      logic [N-1:0] mask;
      areset    = 1'b1;
      s_arvalid = '0;
      s_rready  = '0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rid     = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rlast   = 1'b0;
      rand_fields();
      #1;
      check("rst_s_arready", 64'(s_arready), 64'(0));
      check("rst_s_rvalid", 64'(s_rvalid), 64'(0));
      check("rst_m_arvalid", 64'(m_arvalid), 64'(0));
      check("rst_m_rready", 64'(m_rready), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_len_err", 64'(len_err), 64'(0));
      check("rst_grant", 64'(grant_id), 64'(0));
      #20;
      areset = 1'b0;
      rr_m   = N - 1;

      for (int i = 0; i < N; i++) begin
         r_len[i] = 8'd0;
      end
      s_arvalid = '1;
      repeat (5) begin
         do_txn(rr_pick(s_arvalid, rr_m), 1, 0, 1'b0, 1'b0);
      end
      s_arvalid = '0;
      tick();

      r_addr[2] = 32'h1000;
      r_len[2]  = 8'd3;
      s_arvalid = 4'b0100;
      do_txn(rr_pick(s_arvalid, rr_m), 4, 0, 1'b0, 1'b1);

      r_len[1]  = 8'd2;
      s_arvalid = 4'b0010;
      do_txn(rr_pick(s_arvalid, rr_m), 3, 5, 1'b1, 1'b1);

      r_len[3]  = 8'd3;
      s_arvalid = 4'b1000;
      do_txn(rr_pick(s_arvalid, rr_m), 2, 0, 1'b0, 1'b1);

      r_len[0]  = 8'd1;
      s_arvalid = 4'b0001;
      do_txn(rr_pick(s_arvalid, rr_m), 4, 0, 1'b0, 1'b1);

      repeat (40) begin
         rand_fields();
         mask = N'($urandom_range(1, (1 << N) - 1));
         g    = rr_pick(mask, rr_m);
         if ($urandom_range(0, 3) == 0) begin
            nb = $urandom_range(1, 8);
         end else begin
            nb = int'(r_len[GW'(g)]) + 1;
         end
         s_arvalid = mask;
         do_txn(g, nb, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'b0);
      end
      s_arvalid = '0;
      tick();

      r_len[0]  = 8'd3;
      s_arvalid = 4'b0001;
      tick();
      check("mid_grant", 64'(grant_id), 64'(0));
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      s_arvalid = '0;
      m_rvalid  = 1'b1;
      s_rready  = 4'b0001;
      tick();
      check("mid_busy", 64'(busy), 64'(1));
      #2;
      areset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_s_rvalid", 64'(s_rvalid), 64'(0));
      check("arst_m_rready", 64'(m_rready), 64'(0));
      check("arst_m_arvalid", 64'(m_arvalid), 64'(0));
      check("arst_len_err", 64'(len_err), 64'(0));
      check("arst_grant", 64'(grant_id), 64'(0));
      m_rvalid  = 1'b0;
      s_rready  = '0;
      @(negedge clk);
      areset    = 1'b0;
      rr_m      = N - 1;
      s_arvalid = 4'b1001;
      tick();
      check("post_rst_grant", 64'(grant_id), 64'(rr_pick(s_arvalid, rr_m)));
      check("post_rst_arvalid", 64'(m_arvalid), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
